frame_position_tracker: RTL
===========================

# frame_position_tracker

- Sits between the camera pixel interface and the encryption core.
- Accepts a valid/ready pixel stream with a start-of-frame marker.
- Tags every accepted pixel with its column, row, end-of-line, end-of-frame and a running frame number; the encryption core uses the frame number as a per-frame nonce.
- Provides a one-entry registered output stage with full back-pressure support.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: pixel data width.
- `FRAME_WIDTH`, 640: pixels per line.
- `FRAME_HEIGHT`, 480: lines per frame.
- `COL_WIDTH`, 10: width of the column index; must satisfy 2^COL_WIDTH ≥ FRAME_WIDTH.
- `ROW_WIDTH`, 9: width of the row index; must satisfy 2^ROW_WIDTH ≥ FRAME_HEIGHT.
- `FRAME_CNT_WIDTH`, 16: width of the frame number.

**Ports**
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low reset. Sampled on the `clk` rising edge; 0 = reset.
- `in_data`, input, DATA_WIDTH: pixel data.
- `in_sof`, input, 1: qualified by `in_valid`; marks the first pixel of a frame.
- `in_valid`, input, 1: input pixel present.
- `in_ready`, output, 1: block can accept a pixel this cycle.
- `out_data`, output, DATA_WIDTH: registered pixel data.
- `out_col`, output, COL_WIDTH: column index of `out_data`.
- `out_row`, output, ROW_WIDTH: row index of `out_data`.
- `out_eol`, output, 1: `out_col` == FRAME_WIDTH-1.
- `out_eof`, output, 1: last pixel of the frame.
- `out_frame`, output, FRAME_CNT_WIDTH: frame number of the pixel.
- `out_valid`, output, 1: output register holds a pixel.
- `out_ready`, input, 1: downstream accepts the output pixel.
- `err_resync`, output, 1: one-cycle pulse when `in_sof` arrives mid-frame.

## Operation

**Handshakes**
- Input transfer occurs when `in_valid && in_ready`.
- Output transfer occurs when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and has no path from `in_valid`.

**State machine**

WAIT_SOF:
- Transferred pixels with `in_sof`=0 are accepted and discarded; `out_valid` is not set.
- A transferred pixel with `in_sof`=1 is loaded into the output register with col=0, row=0 and frame number F. Go to ACTIVE.

ACTIVE, per transferred pixel:
- If `in_sof`=1 (resync):
  - Load the pixel as col=0, row=0, frame=F+1.
  - Set F=F+1 and pulse `err_resync`.
  - Stay in ACTIVE.
- Otherwise, tag the pixel with the next position:
  - col+1 normally.
  - At col=FRAME_WIDTH-1: col=0 and row+1.
- The pixel at col=FRAME_WIDTH-1, row=FRAME_HEIGHT-1 carries `out_eof`=1. After it loads, increment F (wrapping modulo 2^FRAME_CNT_WIDTH) and go to WAIT_SOF.

**Position and frame state**
- Internal next-col, next-row and frame-number registers update only on input transfers.
- Stall cycles never advance them.
- Column and row comparisons use full-width equality.
- The frame number wraps from 2^FRAME_CNT_WIDTH-1 to 0.

**Output register**
- All `out_*` fields load together on an input transfer that produces an output.
- They hold stable while `out_valid && !out_ready`.
- `out_valid` clears on an output transfer with no new load in the same cycle.
- Simultaneous output transfer and new load: `out_valid` stays 1 and the register takes the new pixel.

**Reset (`reset`=0)**
- Applies on the clock edge, including mid-frame.
- Forces state=WAIT_SOF, `out_valid`=0, F=0 and `err_resync`=0.
- Forces `out_data`, `out_col`, `out_row`, `out_eol`, `out_eof`, `out_frame` to 0.
- The pixel in flight at reset is dropped.
- `in_ready`=1 in the first cycle after reset.

## Timing

- Latency: a pixel transferred at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput: one pixel per cycle while `out_ready`=1.
- `err_resync` is asserted in the same cycle as the resynced pixel's `out_valid` and lasts exactly one cycle.
- `out_eol` and `out_eof` are registered alongside the data. No combinational input-to-output paths except `out_ready`→`in_ready`.

## Test plan

Use FRAME_WIDTH=4, FRAME_HEIGHT=3, FRAME_CNT_WIDTH=2 for all scenarios.

1. **Basic frame.** Reset, then 12 back-to-back pixels (first with `in_sof`) and `out_ready`=1.
   - Outputs (col,row) go (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2).
   - `out_eol` is set on cols 3; `out_eof` only on the 12th pixel; `out_frame`=0 throughout.
   - `out_valid` rises one cycle after the first transfer.
2. **Pre-SOF discard.** Send 3 pixels without `in_sof`, then a frame.
   - `out_valid` stays 0 for the first 3 pixels.
   - The first output is the SOF pixel at (0,0).
3. **Back-pressure.** Hold `out_ready`=0 for 5 cycles mid-line at col 1.
   - `in_ready`=0 and `out_*` stay frozen at col 1.
   - After release, the next output is col 2 with no pixel lost or duplicated.
4. **Resync.** Assert `in_sof` at (2,1) of frame 0.
   - That pixel outputs (0,0) with `out_frame`=1 and `err_resync` high for one cycle.
   - A subsequent full frame ends with `out_eof` and the next frame has `out_frame`=2.
5. **Frame wrap.** Run 5 complete frames.
   - `out_frame` sequence is 0,1,2,3,0.
6. **Mid-frame reset.** Pull `reset` low at (1,1) with `out_valid`=1 and `out_ready`=0.
   - Next cycle: all outputs are 0, `in_ready`=1.
   - A non-SOF pixel is then discarded; an SOF pixel outputs (0,0) with frame 0.

Source files
------------

// File: rtl/frame_position_tracker.sv
// Tags a valid/ready pixel stream with column, row, eol/eof and frame number.
// The tagged pixel sits in a single registered output slot with back-pressure.
module frame_position_tracker #(
    parameter int DATA_WIDTH      = 8,
    parameter int FRAME_WIDTH     = 640,
    parameter int FRAME_HEIGHT    = 480,
    parameter int COL_WIDTH       = 10,
    parameter int ROW_WIDTH       = 9,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_sof,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [COL_WIDTH-1:0]       out_col,
    output logic [ROW_WIDTH-1:0]       out_row,
    output logic                       out_eol,
    output logic                       out_eof,
    output logic [FRAME_CNT_WIDTH-1:0] out_frame,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err_resync
);

    localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(FRAME_HEIGHT - 1);

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t                     state_q, state_d;
    logic [COL_WIDTH-1:0]       next_col_q, next_col_d;
    logic [ROW_WIDTH-1:0]       next_row_q, next_row_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_q, frame_d;
    logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
    logic [COL_WIDTH-1:0]       out_col_q, out_col_d;
    logic [ROW_WIDTH-1:0]       out_row_q, out_row_d;
    logic                       out_eol_q, out_eol_d;
    logic                       out_eof_q, out_eof_d;
    logic [FRAME_CNT_WIDTH-1:0] out_frame_q, out_frame_d;
    logic                       out_valid_q, out_valid_d;
    logic                       err_resync_q, err_resync_d;

    logic                       in_xfer;
    logic                       load;
    logic                       resync;
    logic [COL_WIDTH-1:0]       pix_col;
    logic [ROW_WIDTH-1:0]       pix_row;
    logic [FRAME_CNT_WIDTH-1:0] pix_frame;
    logic                       pix_eol;
    logic                       pix_eof;

    // The slot can take a pixel when empty or when it drains this cycle.
    assign in_ready = !out_valid_q || out_ready;

    assign out_data   = out_data_q;
    assign out_col    = out_col_q;
    assign out_row    = out_row_q;
    assign out_eol    = out_eol_q;
    assign out_eof    = out_eof_q;
    assign out_frame  = out_frame_q;
    assign out_valid  = out_valid_q;
    assign err_resync = err_resync_q;

    // Classify the incoming pixel and work out the tag it would carry.
    always_comb begin
        in_xfer   = in_valid && in_ready;
        load      = in_xfer && ((state_q == ACTIVE) || in_sof);
        resync    = in_xfer && (state_q == ACTIVE) && in_sof;
        pix_col   = in_sof ? '0 : next_col_q;
        pix_row   = in_sof ? '0 : next_row_q;
        pix_frame = resync ? frame_q + 1'b1 : frame_q;
        pix_eol   = (pix_col == LAST_COL);
        pix_eof   = pix_eol && (pix_row == LAST_ROW);
    end

    // Next-state: position/frame tracking and the output slot.
    always_comb begin
        state_d      = state_q;
        next_col_d   = next_col_q;
        next_row_d   = next_row_q;
        frame_d      = frame_q;
        out_data_d   = out_data_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        out_frame_d  = out_frame_q;
        out_valid_d  = out_valid_q;
        err_resync_d = resync;

        if (load) begin
            out_data_d  = in_data;
            out_col_d   = pix_col;
            out_row_d   = pix_row;
            out_eol_d   = pix_eol;
            out_eof_d   = pix_eof;
            out_frame_d = pix_frame;
            out_valid_d = 1'b1;
            if (pix_eol) begin
                next_col_d = '0;
                next_row_d = pix_row + 1'b1;
            end else begin
                next_col_d = pix_col + 1'b1;
                next_row_d = pix_row;
            end
            if (pix_eof) begin
                frame_d = pix_frame + 1'b1;
                state_d = WAIT_SOF;
            end else begin
                frame_d = pix_frame;
                state_d = ACTIVE;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= WAIT_SOF;
            next_col_q   <= '0;
            next_row_q   <= '0;
            frame_q      <= '0;
            out_data_q   <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_frame_q  <= '0;
            out_valid_q  <= 1'b0;
            err_resync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_col_q   <= next_col_d;
            next_row_q   <= next_row_d;
            frame_q      <= frame_d;
            out_data_q   <= out_data_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            out_frame_q  <= out_frame_d;
            out_valid_q  <= out_valid_d;
            err_resync_q <= err_resync_d;
        end
    end

endmodule
